// File: rtl/shift_seq_unit_pkg.sv
// Shared encodings for the multicycle shift unit: op codes, FSM states and op legality.
package shift_seq_unit_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] SH_NOP = 3'b000;
  localparam logic [OP_W-1:0] SH_SLL = 3'b001;
  localparam logic [OP_W-1:0] SH_SRL = 3'b010;
  localparam logic [OP_W-1:0] SH_SRA = 3'b011;
  localparam logic [OP_W-1:0] SH_ROR = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Only SLL, SRL, SRA and ROR perform a shift; every other code passes the operand through.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op == SH_SLL) || (op == SH_SRL) || (op == SH_SRA) || (op == SH_ROR);
  endfunction

endpackage

// File: rtl/shift_seq_unit_shift_step.sv
// Combinational single-bit shift/rotate of a WIDTH vector, selected by op.
module shift_step
  import shift_seq_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout_c
);

  always_comb begin
    dout_c = din;
    case (op)
      SH_SLL:  dout_c = {din[WIDTH-2:0], 1'b0};
      SH_SRL:  dout_c = {1'b0, din[WIDTH-1:1]};
      SH_SRA:  dout_c = {din[WIDTH-1], din[WIDTH-1:1]};
      SH_ROR:  dout_c = {din[0], din[WIDTH-1:1]};
      default: dout_c = din;
    endcase
  end

endmodule

// File: rtl/shift_seq_unit.sv
// Multicycle shift unit: captures an operand on start, shifts one bit per clock,
// pulses done for one cycle and holds the result until the next accepted start.
module shift_seq_unit
  import shift_seq_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] ent32,
  input  logic [AMT_W-1:0] shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_t           state;
  logic [AMT_W-1:0] cnt;
  logic [OP_W-1:0]  op_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] step_c;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op     (op_q),
    .din    (data_q),
    .dout_c (step_c)
  );

  // Single FSM process; busy/done are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      data_q <= '0;
      cnt    <= '0;
      op_q   <= SH_NOP;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            data_q <= ent32;
            cnt    <= shamt;
            op_q   <= op;
            if ((shamt != '0) && op_legal(op)) begin
              state <= ST_SHIFT;
              busy  <= 1'b1;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          data_q <= step_c;
          cnt    <= cnt - AMT_W'(1);
          if (cnt == AMT_W'(1)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign result = data_q;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Directed self-checking bench for shift_seq_unit with hand-computed expectations.
module tb_shift_seq_unit;
  import shift_seq_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] ent32;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  shift_seq_unit #(.WIDTH(32), .AMT_W(5)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .ent32  (ent32),
    .shamt  (shamt),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from IDLE and wait (bounded) for done; returns latency, busy cycles, result.
  task automatic run_op(input logic [2:0] o, input logic [31:0] e, input logic [4:0] a,
                        output int cyc, output int bcnt, output logic [31:0] res);
    op = o; ent32 = e; shamt = a; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    bcnt = busy ? 1 : 0;
    while (!done && cyc < 64) begin
      tick();
      cyc++;
      if (busy) bcnt++;
    end
    check("done_within_budget", 32'(done), 32'd1);
    check("busy_low_with_done", 32'(busy), 32'd0);
    res = result;
    tick();
    check("done_single_pulse", 32'(done), 32'd0);
  endtask

  int          cyc;
  int          bcnt;
  int          seen_done;
  logic [31:0] res;
  logic [31:0] exp;

  initial begin
    reset = 1'b1; start = 1'b0; op = SH_NOP; ent32 = '0; shamt = '0;
    tick(); tick();
    check("reset_busy",   32'(busy), 32'd0);
    check("reset_done",   32'(done), 32'd0);
    check("reset_result", result,    32'd0);
    reset = 1'b0;
    tick();

    // Reset asserted on the 4th SHIFT cycle of an SLL by 10.
    op = SH_SLL; ent32 = 32'h0000_0001; shamt = 5'd10; start = 1'b1;
    tick();
    start = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) seen_done++;
    end
    check("mid_shift_value", result, 32'h0000_0008);
    reset = 1'b1;
    tick();
    if (done) seen_done++;
    check("midrst_busy",   32'(busy), 32'd0);
    check("midrst_result", result,    32'd0);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) seen_done++;
    end
    check("midrst_no_done", 32'(seen_done), 32'd0);
    run_op(SH_SLL, 32'h0000_0001, 5'd3, cyc, bcnt, res);
    check("post_rst_result",  res, 32'h0000_0008);
    check("post_rst_latency", 32'(cyc), 32'd4);

    // SLL by 31.
    run_op(SH_SLL, 32'h0000_0001, 5'd31, cyc, bcnt, res);
    check("sll31_result",  res, 32'h8000_0000);
    check("sll31_latency", 32'(cyc), 32'd32);
    check("sll31_busy",    32'(bcnt), 32'd31);
    check("sll31_held",    result, 32'h8000_0000);

    // SRA vs SRL on a negative operand.
    run_op(SH_SRA, 32'h8000_00F0, 5'd4, cyc, bcnt, res);
    check("sra_result",  res, 32'hF800_000F);
    check("sra_latency", 32'(cyc), 32'd5);
    run_op(SH_SRL, 32'h8000_00F0, 5'd4, cyc, bcnt, res);
    check("srl_result",  res, 32'h0800_000F);
    check("srl_latency", 32'(cyc), 32'd5);

    // Rotate and zero-amount.
    run_op(SH_ROR, 32'h0000_0003, 5'd1, cyc, bcnt, res);
    check("ror_result",  res, 32'h8000_0001);
    check("ror_latency", 32'(cyc), 32'd2);
    run_op(SH_SLL, 32'hDEAD_BEEF, 5'd0, cyc, bcnt, res);
    check("zero_result",  res, 32'hDEAD_BEEF);
    check("zero_latency", 32'(cyc), 32'd1);
    check("zero_busy",    32'(bcnt), 32'd0);

    // Illegal op passes the operand straight through.
    run_op(3'b111, 32'hA5A5_5A5A, 5'd7, cyc, bcnt, res);
    check("illegal_result",  res, 32'hA5A5_5A5A);
    check("illegal_latency", 32'(cyc), 32'd1);

    // start held high with a changing operand during an SRL by 5.
    op = SH_SRL; ent32 = 32'hF000_0000; shamt = 5'd5; start = 1'b1;
    tick();
    check("hold_capture", result, 32'hF000_0000);
    check("hold_busy",    32'(busy), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      ent32 = $urandom;
      tick();
      exp = 32'hF000_0000 >> i;
      check("hold_step", result, exp);
    end
    check("hold_done", 32'(done), 32'd1);
    ent32 = 32'h1111_1111;
    tick();
    check("hold_ignored_busy",   32'(busy), 32'd0);
    check("hold_ignored_result", result,    32'h0780_0000);
    ent32 = 32'h1234_5678;
    tick();
    start = 1'b0;
    check("recapture_busy",   32'(busy), 32'd1);
    check("recapture_result", result,    32'h1234_5678);
    cyc = 1;
    while (!done && cyc < 64) begin
      tick();
      cyc++;
    end
    check("recapture_done",    32'(done), 32'd1);
    check("recapture_latency", 32'(cyc), 32'd6);
    check("recapture_final",   result, 32'h0091_A2B3);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_seq_unit.md
# shift_seq_unit

Multicycle shift unit that consumes the 32-bit shift operand chosen by the shift-entry source select (immediate, register B or register A) together with a 5-bit shift amount. It performs one single-bit shift per clock under a start/done handshake with the control unit. The result is held stable for write-back into the register bank. It sits in the datapath between the shift-entry source select and the write-data mux.

## Interface

Parameters:
- WIDTH, 32, operand/result width
- AMT_W, 5, shift-amount width (log2 WIDTH)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- op  input  3  shift operation code (shared package encoding)
- ent32  input  WIDTH  shift operand from the shift-entry source select
- shamt  input  AMT_W  shift amount, 0..31
- busy  output  1  high in LOAD-accepted/SHIFT states
- done  output  1  one-cycle pulse, result valid
- result  output  WIDTH  shifted value, held until next accepted start

## Operation

- States: IDLE, SHIFT, DONE.
- IDLE + start=1:
  - Capture ent32 into the data register, shamt into the counter, and op into the op register.
  - Next state is SHIFT if shamt≠0 and op is legal; otherwise DONE.
- SHIFT: each cycle, apply one 1-bit step to the data register and decrement the counter.
  - When the counter is 1 before decrement, next state is DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Operations:
  - SLL: shift left, fill 0.
  - SRL: shift right, fill 0.
  - SRA: shift right, fill with bit WIDTH-1.
  - ROR: rotate right; bit 0 moves to bit WIDTH-1.
- Illegal op (000, 101..111): no shift; result = captured ent32; goes directly to DONE.
- result is the data register itself: visible during SHIFT as an intermediate value, final in DONE, held in IDLE.
- start while busy or in DONE is ignored; it is not queued.
- ent32, shamt and op changes after capture have no effect.
- Counter width is AMT_W; no wrap-around is possible because shamt ≤ WIDTH-1.

## Timing

- Reset (any state, including mid-shift): state=IDLE, busy=0, done=0, result=0, counter=0. The operation in progress is aborted with no done pulse.
- Capture edge E0: start high in IDLE.
- Shifts occur on edges E1..Ek, where k=shamt.
- done is high in the cycle after edge Ek; for k=0 it is high in the cycle after E0.
- Latency from the capture edge to done high: k+1 cycles.
- busy is high from after E0 until DONE is entered. busy=0 while done=1.
- Back-to-back operation: start asserted in the cycle done=1 is ignored. The earliest accepted start is the cycle after done, when the unit is in IDLE.
- No combinational path from inputs to outputs.

## Structure

- Shared package:
  - op encoding constants SH_NOP=3'b000, SH_SLL=3'b001, SH_SRL=3'b010, SH_SRA=3'b011, SH_ROR=3'b100.
  - State encoding constants ST_IDLE, ST_SHIFT, ST_DONE.
- Sub-module shift_step: purely combinational one-bit shift of a WIDTH vector selected by op. It is instantiated once and feeds the data register.
- Top-level contents: FSM, counter, data register, op register.

## Test plan

- Reset during SHIFT: start SLL, ent32=0x0000_0001, shamt=10; assert reset on the 4th SHIFT cycle. Required: busy=0, result=0, no done pulse, and a following start works normally.
- SLL: ent32=0x0000_0001, shamt=31. Required: done exactly 32 cycles after the capture edge, result=0x8000_0000, busy high for 31 cycles.
- SRA vs SRL: ent32=0x8000_00F0, shamt=4.
  - SRA: result=0xF800_000F.
  - SRL: result=0x0800_000F.
  - Both: done 5 cycles after capture.
- ROR and zero amount:
  - ent32=0x0000_0003, ROR, shamt=1: result=0x8000_0001.
  - shamt=0, SLL, ent32=0xDEAD_BEEF: done 1 cycle after capture, result=0xDEAD_BEEF.
- Handshake robustness:
  - Hold start high continuously with varying ent32 during a shamt=5 SRL. Required: the operand does not change mid-operation, and a new capture occurs only in the cycle after done.
  - Illegal op=3'b111: result=ent32 and done after 1 cycle.
